receive: RTL
============

Name: receive

Overview:
- Serial receiver directly downstream of the `transmit` stage.
- Deserialises its line frames back into bytes and presents each byte on a valid/ack handshake.
- Raises one-cycle error pulses on malformed frames or when a byte is lost.
- Shares the clock domain with the transmitter and uses the same `connection_status` enable.

Parameters:
- CLKS_PER_BIT, default 1: clocks per serial bit. 1 matches the transmitter's one-bit-per-clock rate. Legal range is 1..1024.
- SYNC_STAGES, default 2: number of input synchroniser flops on `rxd`. Legal range is 2..3.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- connection_status  in  1  receiver enable. 0 forces IDLE.
- rxd  in  1  serial line. Idle level is 1.
- rx_word  out  8  last accepted byte.
- rx_valid  out  1  `rx_word` holds an unconsumed byte.
- rx_ack  in  1  consumer accepts `rx_word` in any cycle where `rx_valid` is 1.
- frame_error  out  1  one-cycle pulse: marker bit was not 0.
- overrun  out  1  one-cycle pulse: a frame completed while `rx_valid` was still 1.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Frame format:
  - start bit 0;
  - 8 data bits, LSB first;
  - marker bit 0;
  - line high (idle) for at least 1 bit time before the next start bit.
- Reset values (`rst` = 0, asynchronous):
  - rx_word = 8'h00; rx_valid, frame_error, overrun, busy = 0;
  - synchroniser flops = 1; FSM = IDLE; all counters = 0.
- Synchroniser: `rxd` passes through SYNC_STAGES flops giving `rxd_s`. All FSM decisions use `rxd_s` only.
- Sample timing:
  - HALF = (CLKS_PER_BIT-1)/2.
  - A bit counter `bcnt` (3 bits) and a clock counter `ccnt` (width max(1, clog2(CLKS_PER_BIT))) drive sampling.
  - A "sample tick" occurs when `ccnt` reaches CLKS_PER_BIT-1 after the start bit is confirmed. `ccnt` then reloads to 0.
- States:
  - IDLE:
    - `rxd_s` = 0 → START, `ccnt` = 0.
  - START:
    - When `ccnt` = HALF, if `rxd_s` = 0 → DATA, `bcnt` = 0, `ccnt` = 0.
    - Otherwise (false start / glitch) → IDLE, with no outputs.
    - With CLKS_PER_BIT = 1 the start bit is confirmed in the same cycle it is detected.
  - DATA:
    - On each sample tick, shift `rxd_s` into bit[7] of the shift register (shift right), then `bcnt`++.
    - After the 8th tick → MARK.
  - MARK: on the sample tick:
    - `rxd_s` = 0, `rx_valid` = 0 (or `rx_ack` = 1 this cycle): `rx_word` = shift register, `rx_valid` = 1 next cycle.
    - `rxd_s` = 0, `rx_valid` = 1 with no ack: byte discarded, `overrun` pulses, `rx_word` unchanged.
    - `rxd_s` = 1: `frame_error` pulses, byte discarded.
    - In all three cases → WAIT_IDLE.
  - WAIT_IDLE:
    - Stay until `rxd_s` = 1, then → IDLE.
    - This rejects a line stuck low; no repeated error is raised.
- Handshake:
  - `rx_ack` while `rx_valid` = 1 clears `rx_valid` next cycle.
  - `rx_ack` while `rx_valid` = 0 is ignored.
  - If `rx_ack` and a new-byte load occur in the same cycle, the load wins: `rx_valid` stays 1 and `rx_word` is updated.
- Latency: `rx_valid` rises on the clock after the marker-bit sample tick.
  - With CLKS_PER_BIT = 1 and SYNC_STAGES = 2, that is 12 clocks after the start bit's first clock on `rxd`.
- `connection_status` = 0:
  - FSM → IDLE next cycle; `bcnt`/`ccnt` cleared; no error pulses.
  - `rx_word` and `rx_valid` are held, and `rx_ack` still works.
- Reset mid-frame: all state returns to reset values immediately. The partial byte is never presented.
- `busy` = 1 in START, DATA, MARK and WAIT_IDLE.

Decomposition:
- Package `uart_pkg`:
  - state enum {IDLE, START, DATA, MARK, WAIT_IDLE};
  - constants DATA_BITS = 8, START_LEVEL = 0, MARKER_LEVEL = 0, IDLE_LEVEL = 1.
- Sub-module `bit_sync`: parameterised flop chain (SYNC_STAGES) with asynchronous active-low reset to 1. It is instantiated once, on `rxd`.

Test Plan:
- Loopback from `transmit` (CLKS_PER_BIT = 1), word 8'hA5 then 8'h3C back-to-back, `rx_ack` tied 1 → `rx_valid` pulses twice with `rx_word` = A5 then 3C; no errors.
- CLKS_PER_BIT = 8, `rxd` low for 2 clocks then high → FSM returns to IDLE; no `rx_valid`, `frame_error` or `overrun`.
- CLKS_PER_BIT = 4, frame with 8'h81 and marker bit = 1 → `frame_error` single pulse; `rx_valid` stays 0; `rx_word` unchanged (00).
- Two frames 8'h11 then 8'h22, `rx_ack` held 0 → first gives `rx_valid` = 1 with `rx_word` = 11; second gives an `overrun` pulse and `rx_word` stays 11. Then assert `rx_ack` → `rx_valid` = 0.
- `rst` asserted during data bit 4 of 8'hFF, then released, then a clean 8'h5A frame → no output from the first frame; `rx_word` = 5A.
- `connection_status` dropped mid-frame for 3 clocks, then restored with the line idle → `busy` = 0 within 1 clock; the next clean frame 8'h0F is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the serial receive path.
//   state_e      : receiver FSM states
//   DATA_BITS    : payload bits per frame
//   *_LEVEL      : line levels for start bit, marker bit and idle line
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    MARK      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_e;

  localparam int unsigned DATA_BITS    = 8;
  localparam logic        START_LEVEL  = 1'b0;
  localparam logic        MARKER_LEVEL = 1'b0;
  localparam logic        IDLE_LEVEL   = 1'b1;

endpackage

// File: rtl/receive_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous line.
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset; every stage resets to the idle level
//   d     : asynchronous input
//   q     : synchronised output (STAGES clocks of latency)
module bit_sync
  import uart_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{IDLE_LEVEL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/receive.sv
// Serial frame receiver: start(0), 8 data bits LSB first, marker(0), idle(1).
//   clk               : system clock
//   rst               : asynchronous active-low reset
//   connection_status : receiver enable; 0 forces the FSM back to IDLE
//   rxd               : serial line (idle high)
//   rx_word           : last accepted byte
//   rx_valid          : rx_word holds an unconsumed byte
//   rx_ack            : consumer accepts rx_word while rx_valid is 1
//   frame_error       : one-cycle pulse, marker bit sampled high
//   overrun           : one-cycle pulse, frame completed while rx_valid still 1
//   busy              : FSM is not in IDLE
module receive
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       connection_status,
  input  logic       rxd,
  output logic [7:0] rx_word,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned   CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic rxd_s;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (rxd),
    .q     (rxd_s)
  );

  state_e        state_q, state_d;
  logic [2:0]    bcnt_q,  bcnt_d;
  logic [CW-1:0] ccnt_q,  ccnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    word_q,  word_d;
  logic          valid_q, valid_d;
  logic          ferr_q,  ferr_d;
  logic          ovr_q,   ovr_d;
  logic          tick;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    ccnt_d  = ccnt_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    tick    = (ccnt_q == LAST);

    // Handshake runs independently of the enable; a load below overrides it.
    if (rx_ack && valid_q) begin
      valid_d = 1'b0;
    end

    if (!connection_status) begin
      state_d = IDLE;
      bcnt_d  = '0;
      ccnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rxd_s == START_LEVEL) begin
            ccnt_d = '0;
            // At one clock per bit there is no mid-bit to wait for, so the
            // detecting cycle also confirms the start bit.
            if (CLKS_PER_BIT == 1) begin
              state_d = DATA;
              bcnt_d  = '0;
            end else begin
              state_d = START;
            end
          end
        end
        START: begin
          if (ccnt_q == HALF) begin
            ccnt_d  = '0;
            bcnt_d  = '0;
            state_d = (rxd_s == START_LEVEL) ? DATA : IDLE;
          end else begin
            ccnt_d = ccnt_q + CW'(1);
          end
        end
        DATA: begin
          if (tick) begin
            ccnt_d  = '0;
            shreg_d = {rxd_s, shreg_q[7:1]};
            bcnt_d  = bcnt_q + 3'd1;
            if (bcnt_q == 3'(DATA_BITS - 1)) begin
              state_d = MARK;
            end
          end else begin
            ccnt_d = ccnt_q + CW'(1);
          end
        end
        MARK: begin
          if (tick) begin
            ccnt_d  = '0;
            state_d = WAIT_IDLE;
            if (rxd_s != MARKER_LEVEL) begin
              ferr_d = 1'b1;
            end else if (!valid_q || rx_ack) begin
              word_d  = shreg_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ccnt_d = ccnt_q + CW'(1);
          end
        end
        WAIT_IDLE: begin
          if (rxd_s == IDLE_LEVEL) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      ccnt_q  <= '0;
      shreg_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      ccnt_q  <= ccnt_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_word     = word_q;
  assign rx_valid    = valid_q;
  assign frame_error = ferr_q;
  assign overrun     = ovr_q;
  assign busy        = (state_q != IDLE);

endmodule
